// File: rtl/grid_cursor_rpt_if.sv
// Key/limit inputs and cursor outputs of grid_cursor_rpt, bundled for port connection.
// Signal names match the legacy flat ports so existing board logic maps one-to-one.
interface grid_cursor_rpt_if #(
  parameter int COORD_W = 4
);
  logic [COORD_W-1:0] gridWidth;
  logic [COORD_W-1:0] gridHeight;
  logic [3:0]         KEY;
  logic               wrapMode;
  logic [COORD_W-1:0] cursorX;
  logic [COORD_W-1:0] cursorY;
  logic               moved;

  modport master (
    output gridWidth, gridHeight, KEY, wrapMode,
    input  cursorX, cursorY, moved
  );

  modport slave (
    input  gridWidth, gridHeight, KEY, wrapMode,
    output cursorX, cursorY, moved
  );
endinterface

// File: rtl/grid_cursor_rpt.sv
// Grid cursor with per-axis press detection, hold-to-repeat, clamp/wrap edges and move strobe.
// Wrap support is compiled in only when GRID_CURSOR_WRAP_EN is defined; otherwise every edge clamps.
module grid_cursor_rpt #(
  parameter int COORD_W       = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic              clock,
  input  logic              resetn,
  grid_cursor_rpt_if.slave  bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
  typedef enum logic [1:0] {D_NONE = 2'b00, D_PLUS = 2'b01, D_MINUS = 2'b10} dir_t;

  // Index 0 is the X axis, index 1 the Y axis.
  state_t             state_q [2];
  state_t             state_d [2];
  dir_t               dir_q   [2];
  dir_t               dir_now [2];
  logic [CNT_W-1:0]   cnt_q   [2];
  logic [CNT_W-1:0]   cnt_d   [2];
  logic [COORD_W-1:0] pos_q   [2];
  logic [COORD_W-1:0] pos_d   [2];
  logic [COORD_W-1:0] lim     [2];
  logic               step    [2];
  logic               moved_q;
  logic               moved_d;
  logic               wrap;

`ifdef GRID_CURSOR_WRAP_EN
  assign wrap = bus.wrapMode;
`else
  logic unused_wrap;
  assign unused_wrap = bus.wrapMode;
  assign wrap        = 1'b0;
`endif

  function automatic dir_t decode(input logic plus, input logic minus);
    if (plus && !minus)      return D_PLUS;
    else if (minus && !plus) return D_MINUS;
    else                     return D_NONE;
  endfunction

  function automatic logic [COORD_W-1:0] move(input logic [COORD_W-1:0] p,
                                              input logic [COORD_W-1:0] l,
                                              input dir_t d, input logic w);
    logic [COORD_W-1:0] r;
    r = p;
    if (d == D_PLUS) begin
      if (p >= l) r = w ? '0 : p;
      else        r = p + 1'b1;
    end else if (d == D_MINUS) begin
      if (p == '0) r = w ? l : p;
      else         r = p - 1'b1;
    end
    return r;
  endfunction

  assign lim[0]     = bus.gridWidth;
  assign lim[1]     = bus.gridHeight;
  assign dir_now[0] = decode(bus.KEY[0], bus.KEY[3]);
  assign dir_now[1] = decode(bus.KEY[2], bus.KEY[1]);

  always_comb begin
    for (int unsigned a = 0; a < 2; a++) begin
      state_d[a] = state_q[a];
      cnt_d[a]   = cnt_q[a];
      step[a]    = 1'b0;
      if (dir_now[a] == D_NONE) begin
        state_d[a] = S_IDLE;
        cnt_d[a]   = '0;
      end else if (state_q[a] == S_IDLE || dir_now[a] != dir_q[a]) begin
        step[a]    = 1'b1;
        state_d[a] = S_DELAY;
        cnt_d[a]   = CNT_W'(REPEAT_DELAY - 1);
      end else if (cnt_q[a] == '0) begin
        step[a]    = 1'b1;
        state_d[a] = S_REPEAT;
        cnt_d[a]   = CNT_W'(REPEAT_PERIOD - 1);
      end else begin
        cnt_d[a]   = cnt_q[a] - 1'b1;
      end
      // A coordinate beyond a freshly shrunk limit snaps to it, overriding any step.
      if (pos_q[a] > lim[a])  pos_d[a] = lim[a];
      else if (step[a])       pos_d[a] = move(pos_q[a], lim[a], dir_now[a], wrap);
      else                    pos_d[a] = pos_q[a];
    end
    moved_d = (pos_d[0] != pos_q[0]) || (pos_d[1] != pos_q[1]);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned a = 0; a < 2; a++) begin
        state_q[a] <= S_IDLE;
        dir_q[a]   <= D_NONE;
        cnt_q[a]   <= '0;
        pos_q[a]   <= '0;
      end
      moved_q <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < 2; a++) begin
        state_q[a] <= state_d[a];
        dir_q[a]   <= dir_now[a];
        cnt_q[a]   <= cnt_d[a];
        pos_q[a]   <= pos_d[a];
      end
      moved_q <= moved_d;
    end
  end

  assign bus.cursorX = pos_q[0];
  assign bus.cursorY = pos_q[1];
  assign bus.moved   = moved_q;

endmodule

// File: tb/tb_grid_cursor_rpt.sv
// Directed bench for grid_cursor_rpt with default parameters (COORD_W=4, delay 8, period 4).
// Wrap-mode steps are exercised only when GRID_CURSOR_WRAP_EN is defined.
module tb_grid_cursor_rpt;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   ncmp   = 0;
  int   nfail  = 0;
  int   mcount;

  grid_cursor_rpt_if #(.COORD_W(4)) bus ();

  grid_cursor_rpt #(
    .COORD_W      (4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] k);
    bus.KEY = k;
    tick();
    bus.KEY = 4'b0000;
    tick();
  endtask

  initial begin
    bus.KEY        = 4'b0000;
    bus.gridWidth  = 4'd9;
    bus.gridHeight = 4'd9;
    bus.wrapMode   = 1'b0;
    tick();
    tick();
    check("rst_x", 32'(bus.cursorX), 0);
    check("rst_y", 32'(bus.cursorY), 0);
    check("rst_moved", 32'(bus.moved), 0);
    resetn = 1'b1;
    tick();

    // single right press
    bus.KEY = 4'b0001;
    tick();
    check("press_x", 32'(bus.cursorX), 1);
    check("press_y", 32'(bus.cursorY), 0);
    check("press_moved", 32'(bus.moved), 1);
    bus.KEY = 4'b0000;
    tick();
    check("rel_x", 32'(bus.cursorX), 1);
    check("rel_moved", 32'(bus.moved), 0);

    // asynchronous reset between edges, then hold right 20 cycles
    resetn = 1'b0;
    #2;
    check("async_rst_x", 32'(bus.cursorX), 0);
    resetn = 1'b1;
    tick();
    bus.KEY = 4'b0001;
    mcount  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      mcount += int'(bus.moved);
      check($sformatf("hold_x_%0d", i), 32'(bus.cursorX),
            32'(1 + int'(i >= 8) + int'(i >= 12) + int'(i >= 16)));
      check($sformatf("hold_mv_%0d", i), 32'(bus.moved),
            32'(i == 0 || i == 8 || i == 12 || i == 16));
    end
    check("hold_pulses", 32'(mcount), 4);
    bus.KEY = 4'b0000;
    tick();
    check("hold_rel_x", 32'(bus.cursorX), 4);
    check("hold_rel_mv", 32'(bus.moved), 0);

    // opposite keys cancel; releasing one starts a fresh press
    pulse(4'b1000);
    check("to3_x", 32'(bus.cursorX), 3);
    bus.KEY = 4'b1001;
    mcount  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      mcount += int'(bus.moved);
    end
    check("both_x", 32'(bus.cursorX), 3);
    check("both_pulses", 32'(mcount), 0);
    bus.KEY = 4'b1000;
    tick();
    check("left_only_x", 32'(bus.cursorX), 2);
    check("left_only_mv", 32'(bus.moved), 1);
    bus.KEY = 4'b0000;
    tick();

    // hold right until clamped at the limit
    bus.KEY = 4'b0001;
    mcount  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      mcount += int'(bus.moved);
    end
    check("clamp_hold_x", 32'(bus.cursorX), 9);
    check("clamp_hold_pulses", 32'(mcount), 7);
    bus.KEY = 4'b0000;
    tick();
    bus.KEY = 4'b0001;
    tick();
    check("clamp_x", 32'(bus.cursorX), 9);
    check("clamp_mv", 32'(bus.moved), 0);
    bus.KEY = 4'b0000;
    tick();

`ifdef GRID_CURSOR_WRAP_EN
    bus.wrapMode = 1'b1;
    bus.KEY = 4'b0001;
    tick();
    check("wrap_hi_x", 32'(bus.cursorX), 0);
    check("wrap_hi_mv", 32'(bus.moved), 1);
    bus.KEY = 4'b0000;
    tick();
    bus.KEY = 4'b1000;
    tick();
    check("wrap_lo_x", 32'(bus.cursorX), 9);
    check("wrap_lo_mv", 32'(bus.moved), 1);
    bus.KEY = 4'b0000;
    tick();
    bus.wrapMode = 1'b0;
`else
    bus.wrapMode = 1'b1;
    bus.KEY = 4'b0001;
    tick();
    check("nowrap_x", 32'(bus.cursorX), 9);
    check("nowrap_mv", 32'(bus.moved), 0);
    bus.KEY = 4'b0000;
    tick();
    bus.wrapMode = 1'b0;
`endif

    // limit shrink overrides a held right key
    pulse(4'b1000);
    pulse(4'b1000);
    check("to7_x", 32'(bus.cursorX), 7);
    bus.KEY       = 4'b0001;
    bus.gridWidth = 4'd5;
    tick();
    check("shrink_x", 32'(bus.cursorX), 5);
    check("shrink_mv", 32'(bus.moved), 1);
    tick();
    check("shrink_hold_x", 32'(bus.cursorX), 5);
    check("shrink_hold_mv", 32'(bus.moved), 0);
    bus.KEY       = 4'b0000;
    bus.gridWidth = 4'd9;
    tick();

    // down at Y=0 clamps
    bus.KEY = 4'b0010;
    tick();
    check("y_clamp0", 32'(bus.cursorY), 0);
    check("y_clamp0_mv", 32'(bus.moved), 0);
    bus.KEY = 4'b0000;
    tick();

    // simultaneous X and Y steps give one pulse
    bus.KEY = 4'b0101;
    tick();
    check("diag_x", 32'(bus.cursorX), 6);
    check("diag_y", 32'(bus.cursorY), 1);
    check("diag_mv", 32'(bus.moved), 1);
    tick();
    check("diag_mv_end", 32'(bus.moved), 0);
    bus.KEY = 4'b0000;
    tick();

    // reset mid-repeat, then fresh press on release
    bus.KEY = 4'b0100;
    for (int i = 0; i < 10; i++) tick();
    check("up_hold_y", 32'(bus.cursorY), 3);
    resetn = 1'b0;
    #1;
    check("midrst_y", 32'(bus.cursorY), 0);
    check("midrst_x", 32'(bus.cursorX), 0);
    check("midrst_mv", 32'(bus.moved), 0);
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_y", 32'(bus.cursorY), 1);
    check("post_rst_mv", 32'(bus.moved), 1);
    for (int i = 0; i < 7; i++) tick();
    check("post_rst_y7", 32'(bus.cursorY), 1);
    tick();
    check("post_rst_y8", 32'(bus.cursorY), 2);
    bus.KEY = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
